// File: rtl/decode_pkg.sv
// Shared definitions for the multi-issue decoder.
//   ctrl_t    : per-slot control word (13 bits, illegal flag in bit 0)
//   aluop_e   : ALU operation encodings
//   OPC_*     : 6-bit major opcodes recognised by the slot decoder
//   occ_e     : skid-buffer occupancy states
//   mk_ctrl() : builds a legal control word from the nine flag bits and an aluop
package decode_pkg;

    localparam int CTRL_W = 13;
    localparam int OPC_W  = 6;

    typedef enum logic [2:0] {
        ALU_RTYPE = 3'b000,
        ALU_ADD   = 3'b001,
        ALU_SUB   = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_LUI   = 3'b110,
        ALU_XOR   = 3'b111
    } aluop_e;

    typedef struct packed {
        logic   regwrite;
        logic   regdst;
        logic   alusrc;
        logic   branchbeq;
        logic   branchneq;
        logic   memwrite;
        logic   memtoreg;
        logic   jump;
        logic   jumplink;
        aluop_e aluop;
        logic   illegal;
    } ctrl_t;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OPC_SLTI  = 6'b001010;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OPC_JAL   = 6'b000011;
    localparam logic [OPC_W-1:0] OPC_XORI  = 6'b001110;
    localparam logic [OPC_W-1:0] OPC_LUI   = 6'b001111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } occ_e;

    // flags = {regwrite,regdst,alusrc,beq,bne,memwrite,memtoreg,jump,jumplink}
    function automatic ctrl_t mk_ctrl(input logic [8:0] flags, input aluop_e op);
        return ctrl_t'({flags, op, 1'b0});
    endfunction

endpackage

// File: rtl/slot_decoder.sv
// Combinational decode of one instruction slot.
//   i_opcode     : major opcode of the slot
//   i_slot_valid : slot carries a real instruction
//   o_ctrl       : control word; all-zero for an empty slot, illegal-only
//                  for an unrecognised opcode
module slot_decoder
    import decode_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_slot_valid,
    output ctrl_t            o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        if (i_slot_valid) begin
            case (i_opcode)
                OPC_RTYPE: o_ctrl = mk_ctrl(9'b1_100_000_00, ALU_RTYPE);
                OPC_ADDI:  o_ctrl = mk_ctrl(9'b1_010_000_00, ALU_ADD);
                OPC_ANDI:  o_ctrl = mk_ctrl(9'b1_010_000_00, ALU_AND);
                OPC_ORI:   o_ctrl = mk_ctrl(9'b1_010_000_00, ALU_OR);
                OPC_SLTI:  o_ctrl = mk_ctrl(9'b1_010_000_00, ALU_SLT);
                OPC_LW:    o_ctrl = mk_ctrl(9'b1_010_001_00, ALU_ADD);
                OPC_SW:    o_ctrl = mk_ctrl(9'b0_010_010_00, ALU_ADD);
                OPC_BEQ:   o_ctrl = mk_ctrl(9'b0_001_000_00, ALU_SUB);
                OPC_BNE:   o_ctrl = mk_ctrl(9'b0_000_100_00, ALU_SUB);
                OPC_J:     o_ctrl = mk_ctrl(9'b0_010_000_10, ALU_ADD);
                OPC_JAL:   o_ctrl = mk_ctrl(9'b1_010_000_11, ALU_ADD);
                OPC_XORI:  o_ctrl = mk_ctrl(9'b1_010_000_00, ALU_XOR);
                OPC_LUI:   o_ctrl = mk_ctrl(9'b1_010_000_00, ALU_LUI);
                default:   o_ctrl.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multi_issue_decoder.sv
// Multi-issue instruction decoder with a 2-entry in-order skid buffer.
//   clk, reset        : clock, synchronous active-high reset
//   flush             : empties the buffer and drops the concurrent input bundle
//   in_valid/in_ready : input handshake; in_instr/in_slot_valid carry the bundle
//   out_valid/out_ready: output handshake; outputs show the oldest entry
//   out_instr, out_slot_valid : passed through from the accepted bundle
//   out_ctrl          : ISSUE_W control words, slot i at [i*CTRL_W +: CTRL_W]
//   out_illegal_any   : some valid slot of the presented bundle is illegal
//   illegal_cnt       : saturating count of accepted illegal slots
module multi_issue_decoder
    import decode_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int INSTR_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ISSUE_W*INSTR_W-1:0]  in_instr,
    input  logic [ISSUE_W-1:0]          in_slot_valid,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ISSUE_W*INSTR_W-1:0]  out_instr,
    output logic [ISSUE_W-1:0]          out_slot_valid,
    output logic [ISSUE_W*CTRL_W-1:0]   out_ctrl,
    output logic                        out_illegal_any,
    output logic [31:0]                 illegal_cnt
);

    localparam int NCNT_W = 3;  // holds 0..4 illegal slots per bundle

    ctrl_t                      w_ctrl [ISSUE_W];
    logic [ISSUE_W*CTRL_W-1:0]  w_ctrl_flat;
    logic [ISSUE_W-1:0]         w_illegal_vec;
    logic [NCNT_W-1:0]          w_ill_num;
    logic [32:0]                w_cnt_sum;
    logic                       w_push;
    logic                       w_pop;
    occ_e                       r_state;
    occ_e                       w_state_next;

    // Entry 0 is always the oldest; entry 1 is only meaningful when FULL.
    logic [ISSUE_W*INSTR_W-1:0] r_instr     [2];
    logic [ISSUE_W-1:0]         r_slot_vld  [2];
    logic [ISSUE_W*CTRL_W-1:0]  r_ctrl      [2];
    logic                       r_ill_any   [2];
    logic [31:0]                r_illegal_cnt;

    generate
        for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_slot
            slot_decoder u_slot_decoder (
                .i_opcode     (in_instr[gi*INSTR_W + INSTR_W - OPC_W +: OPC_W]),
                .i_slot_valid (in_slot_valid[gi]),
                .o_ctrl       (w_ctrl[gi])
            );
            assign w_ctrl_flat[gi*CTRL_W +: CTRL_W] = w_ctrl[gi];
            assign w_illegal_vec[gi]                = w_ctrl[gi].illegal;
        end
    endgenerate

    always_comb begin
        w_ill_num = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_ill_num = w_ill_num + NCNT_W'(w_illegal_vec[i]);
        end
    end

    // Flush overrides both handshakes so a flushed cycle moves nothing.
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign w_cnt_sum = {1'b0, r_illegal_cnt} + 33'(w_ill_num);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) w_state_next = ST_ONE;
                ST_ONE: begin
                    if (w_push && !w_pop)      w_state_next = ST_FULL;
                    else if (!w_push && w_pop) w_state_next = ST_EMPTY;
                end
                ST_FULL:  if (w_pop) w_state_next = ST_ONE;
                default:  w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs depend on registered state only
    always_comb begin
        in_ready  = (r_state != ST_FULL);
        out_valid = (r_state != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_instr[i]    <= '0;
                r_slot_vld[i] <= '0;
                r_ctrl[i]     <= '0;
                r_ill_any[i]  <= 1'b0;
            end
            r_illegal_cnt <= '0;
        end else begin
            if (w_push) begin
                r_illegal_cnt <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
            end
            if (!flush) begin
                case (r_state)
                    ST_EMPTY: if (w_push) begin
                        r_instr[0]    <= in_instr;
                        r_slot_vld[0] <= in_slot_valid;
                        r_ctrl[0]     <= w_ctrl_flat;
                        r_ill_any[0]  <= |w_illegal_vec;
                    end
                    ST_ONE: if (w_push) begin
                        // Simultaneous pop: the new bundle becomes the oldest.
                        r_instr[w_pop ? 0 : 1]    <= in_instr;
                        r_slot_vld[w_pop ? 0 : 1] <= in_slot_valid;
                        r_ctrl[w_pop ? 0 : 1]     <= w_ctrl_flat;
                        r_ill_any[w_pop ? 0 : 1]  <= |w_illegal_vec;
                    end
                    ST_FULL: if (w_pop) begin
                        r_instr[0]    <= r_instr[1];
                        r_slot_vld[0] <= r_slot_vld[1];
                        r_ctrl[0]     <= r_ctrl[1];
                        r_ill_any[0]  <= r_ill_any[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_instr       = r_instr[0];
    assign out_slot_valid  = r_slot_vld[0];
    assign out_ctrl        = r_ctrl[0];
    assign out_illegal_any = r_ill_any[0];
    assign illegal_cnt     = r_illegal_cnt;

endmodule

// File: tb/tb_multi_issue_decoder.sv
// Scoreboard bench for multi_issue_decoder (ISSUE_W=2, INSTR_W=32).
module tb_multi_issue_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_instr = '0;
    logic [1:0]  in_slot_valid = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_instr;
    logic [1:0]  out_slot_valid;
    logic [25:0] out_ctrl;
    logic        out_illegal_any;
    logic [31:0] illegal_cnt;

    multi_issue_decoder #(.ISSUE_W(2), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_slot_valid(in_slot_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_slot_valid(out_slot_valid),
        .out_ctrl(out_ctrl), .out_illegal_any(out_illegal_any),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    // Hand-computed control words {9 flags, aluop, illegal}
    localparam logic [12:0] C_ZERO = 13'b0;
    localparam logic [12:0] C_R    = 13'b1_100_000_00_000_0;
    localparam logic [12:0] C_ADDI = 13'b1_010_000_00_001_0;
    localparam logic [12:0] C_ANDI = 13'b1_010_000_00_011_0;
    localparam logic [12:0] C_ORI  = 13'b1_010_000_00_100_0;
    localparam logic [12:0] C_SLTI = 13'b1_010_000_00_101_0;
    localparam logic [12:0] C_LW   = 13'b1_010_001_00_001_0;
    localparam logic [12:0] C_SW   = 13'b0_010_010_00_001_0;
    localparam logic [12:0] C_BEQ  = 13'b0_001_000_00_010_0;
    localparam logic [12:0] C_BNE  = 13'b0_000_100_00_010_0;
    localparam logic [12:0] C_J    = 13'b0_010_000_10_001_0;
    localparam logic [12:0] C_JAL  = 13'b1_010_000_11_001_0;
    localparam logic [12:0] C_XORI = 13'b1_010_000_00_111_0;
    localparam logic [12:0] C_LUI  = 13'b1_010_000_00_110_0;
    localparam logic [12:0] C_ILL  = 13'b0_000_000_00_000_1;

    localparam logic [31:0] I_R    = 32'h0109_5020;
    localparam logic [31:0] I_ADDI = 32'h2008_0005;
    localparam logic [31:0] I_ANDI = 32'h3108_00FF;
    localparam logic [31:0] I_ORI  = 32'h3508_0F00;
    localparam logic [31:0] I_SLTI = 32'h2909_0010;
    localparam logic [31:0] I_LW   = 32'h8C09_0000;
    localparam logic [31:0] I_SW   = 32'hAC09_0004;
    localparam logic [31:0] I_BEQ  = 32'h1109_0003;
    localparam logic [31:0] I_BNE  = 32'h1509_FFFC;
    localparam logic [31:0] I_J    = 32'h0810_0000;
    localparam logic [31:0] I_JAL  = 32'h0C10_0040;
    localparam logic [31:0] I_XORI = 32'h3908_5555;
    localparam logic [31:0] I_LUI  = 32'h3C08_1234;
    localparam logic [31:0] I_ILL  = 32'hFC00_0000;
    localparam logic [31:0] I_ILL2 = 32'hDC00_0001;

    typedef struct {
        logic [63:0] instr;
        logic [1:0]  sv;
        logic [25:0] ctrl;
        logic        any;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle that will transfer a bundle is compared against the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got instr %h expected no bundle", out_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_slot_valid", 64'(out_slot_valid), 64'(e.sv));
                chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                chk("out_illegal_any", 64'(out_illegal_any), 64'(e.any));
                $display("pop  instr=%h sv=%b ctrl=%h any=%b", out_instr, out_slot_valid,
                         out_ctrl, out_illegal_any);
            end
        end
    end

    task automatic offer(input logic [31:0] i1, input logic [31:0] i0, input logic [1:0] sv,
                         input logic [12:0] c1, input logic [12:0] c0, input int n_ill,
                         input string tag);
        exp_t e;
        int   n;
        @(negedge clk);
        in_instr      = {i1, i0};
        in_slot_valid = sv;
        in_valid      = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({"accept_", tag}, 64'(in_ready), 64'd1);
        e.instr = {i1, i0};
        e.sv    = sv;
        e.ctrl  = {c1, c0};
        e.any   = (n_ill != 0);
        sb.push_back(e);
        if (64'(exp_cnt) + 64'(n_ill) > 64'hFFFF_FFFF) exp_cnt = 32'hFFFF_FFFF;
        else exp_cnt = exp_cnt + 32'(n_ill);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("push %s instr=%h sv=%b", tag, {i1, i0}, sv);
        chk({"out_valid_after_", tag}, 64'(out_valid), 64'd1);
        chk({"illegal_cnt_", tag}, 64'(illegal_cnt), 64'(exp_cnt));
    endtask

    task automatic flush_with(input logic [31:0] i1, input logic [31:0] i0, input string tag);
        @(negedge clk);
        in_instr      = {i1, i0};
        in_slot_valid = 2'b11;
        in_valid      = 1'b1;
        flush         = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        $display("flush %s instr=%h", tag, {i1, i0});
        chk({"flush_out_valid_", tag}, 64'(out_valid), 64'd0);
        chk({"flush_in_ready_", tag}, 64'(in_ready), 64'd1);
        chk({"flush_illegal_cnt_", tag}, 64'(illegal_cnt), 64'(exp_cnt));
    endtask

    task automatic drain(input string tag);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({"drain_pending_", tag}, 64'(sb.size()), 64'd0);
        chk({"drain_out_valid_", tag}, 64'(out_valid), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({"out_valid_", tag}, 64'(out_valid), 64'd0);
        chk({"in_ready_", tag}, 64'(in_ready), 64'd1);
        chk({"out_ctrl_", tag}, 64'(out_ctrl), 64'd0);
        chk({"out_instr_", tag}, out_instr, 64'd0);
        chk({"out_slot_valid_", tag}, 64'(out_slot_valid), 64'd0);
        chk({"out_illegal_any_", tag}, 64'(out_illegal_any), 64'd0);
        chk({"illegal_cnt_", tag}, 64'(illegal_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_zero("reset");

        // Basic decode with consumer always ready
        out_ready = 1'b1;
        offer(I_LW, I_ADDI, 2'b11, C_LW, C_ADDI, 0, "addi_lw");
        drain("addi_lw");

        // Illegal opcode in slot0, invalid R-type in slot1
        offer(I_R, I_ILL, 2'b01, C_ZERO, C_ILL, 1, "ill_slot0");
        drain("ill_slot0");
        chk("illegal_cnt_one", 64'(illegal_cnt), 64'd1);

        // Opcode sweep, back to back
        offer(I_BNE,  I_BEQ,  2'b11, C_BNE,  C_BEQ,  0, "beq_bne");
        offer(I_JAL,  I_J,    2'b11, C_JAL,  C_J,    0, "j_jal");
        offer(I_R,    I_SW,   2'b11, C_R,    C_SW,   0, "sw_r");
        offer(I_LUI,  I_XORI, 2'b11, C_LUI,  C_XORI, 0, "xori_lui");
        offer(I_ORI,  I_ANDI, 2'b11, C_ORI,  C_ANDI, 0, "andi_ori");
        offer(I_ILL2, I_SLTI, 2'b11, C_ILL,  C_SLTI, 1, "slti_ill");
        offer(I_ILL,  I_ILL,  2'b10, C_ILL,  C_ZERO, 1, "ill_masked");
        offer(I_ADDI, I_LW,   2'b00, C_ZERO, C_ZERO, 0, "no_slots");
        drain("sweep");

        // Backpressure: A and B fill the buffer, C stalls until release
        out_ready = 1'b0;
        offer(I_ADDI, I_R,  2'b11, C_ADDI, C_R,  0, "A");
        offer(I_SW,   I_LW, 2'b11, C_SW,   C_LW, 0, "B");
        chk("in_ready_full", 64'(in_ready), 64'd0);
        fork
            offer(I_J, I_BEQ, 2'b11, C_J, C_BEQ, 0, "C");
            begin
                @(negedge clk);
                @(negedge clk);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_holds_A", out_instr, {I_ADDI, I_R});
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("abc");

        // Flush while FULL with a concurrent illegal bundle
        out_ready = 1'b0;
        offer(I_ILL, I_ADDI, 2'b11, C_ILL, C_ADDI, 1, "D");
        offer(I_R,   I_LW,   2'b11, C_R,   C_LW,   0, "E");
        flush_with(I_ILL, I_ILL2, "full");
        // Flush from ONE while in_ready=1: the offered bundle must not count
        offer(I_ORI, I_ANDI, 2'b11, C_ORI, C_ANDI, 0, "G");
        flush_with(I_ILL2, I_ILL, "one");
        drain("flush");

        // Counter saturation
        @(negedge clk);
        force dut.r_illegal_cnt = 32'hFFFF_FFFE;
        #1 release dut.r_illegal_cnt;
        exp_cnt = 32'hFFFF_FFFE;
        chk("preload_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        offer(I_ILL, I_ILL2, 2'b11, C_ILL, C_ILL, 2, "sat2");
        chk("sat_value", 64'(illegal_cnt), 64'h0000_0000_FFFF_FFFF);
        offer(I_ILL, I_R, 2'b11, C_ILL, C_R, 1, "sat_hold");
        drain("sat");

        // Reset while FULL and stalled, with an offer pending
        out_ready = 1'b0;
        offer(I_ADDI, I_LW, 2'b11, C_ADDI, C_LW, 0, "R1");
        offer(I_SW,   I_R,  2'b11, C_SW,   C_R,  0, "R2");
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_instr = {I_ILL, I_ILL};
        in_slot_valid = 2'b11;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        exp_cnt = '0;
        $display("reset mid-stream");
        check_zero("midreset");

        // Operation resumes after reset
        out_ready = 1'b1;
        offer(I_LUI, I_BNE, 2'b11, C_LUI, C_BNE, 0, "post_reset");
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_issue_decoder.md
MULTI_ISSUE_DECODER -- requirements
Module: multi_issue_decoder

Interface
REQ-001 SHALL have parameter ISSUE_W, default 2: instructions per bundle (1..4).
REQ-002 SHALL have parameter INSTR_W, default 32: instruction width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have reset  input  1  synchronous active-high reset.
REQ-005 SHALL have flush  input  1  drop all buffered and incoming bundles.
REQ-006 SHALL have in_valid  input  1  bundle offered.
REQ-007 SHALL have in_ready  output  1  bundle accepted when in_valid && in_ready.
REQ-008 SHALL have in_instr  input  ISSUE_W*INSTR_W  slot i at bits [i*INSTR_W +: INSTR_W].
REQ-009 SHALL have in_slot_valid  input  ISSUE_W  per-slot valid.
REQ-010 SHALL have out_valid  output  1  decoded bundle available.
REQ-011 SHALL have out_ready  input  1  consumer takes bundle when out_valid && out_ready.
REQ-012 SHALL have out_instr  output  ISSUE_W*INSTR_W  instructions, passed through unchanged.
REQ-013 SHALL have out_slot_valid  output  ISSUE_W  passed through.
REQ-014 SHALL have out_ctrl  output  ISSUE_W*CTRL_W  per-slot control word ctrl_t (CTRL_W = 13).
REQ-015 SHALL have out_illegal_any  output  1  OR of the ctrl_t.illegal fields of valid slots.
REQ-016 SHALL have illegal_cnt  output  32  count of accepted illegal instructions.

Function
REQ-017 ctrl_t SHALL hold regwrite, regdst, alusrc, branchbeq, branchneq, memwrite, memtoreg, jump, jumplink, aluop[2:0], illegal.
REQ-018 Slot decode SHALL map the opcode to {regwrite,regdst,alusrc,beq,bne,memwrite,memtoreg,jump,jumplink,aluop}:
- R-type 000000: 1_100_000_00_000.
- addi 001000: 1_010_000_00_001.
- andi 001100: 1_010_000_00_011.
- ori 001101: 1_010_000_00_100.
- slti 001010: 1_010_000_00_101.
- lw 100011: 1_010_001_00_001.
- sw 101011: 0_010_010_00_001.
- beq 000100: 0_001_000_00_010.
- bne 000101: 0_000_100_00_010.
- j 000010: 0_010_000_10_001.
- jal 000011: 1_010_000_11_001.
- xori 001110 (new): 1_010_000_00_111.
- lui 001111 (new): 1_010_000_00_110.
REQ-019 Any other opcode SHALL yield all-zero controls with illegal=1; decode SHALL be fully specified for every opcode (no latches).
REQ-020 A slot with in_slot_valid=0 SHALL yield an all-zero ctrl_t, including illegal=0.
REQ-021 Decoded bundles SHALL be buffered in a 2-entry in-order skid buffer; the occupancy states are EMPTY, ONE and FULL.
REQ-022 in_ready SHALL be 1 exactly when the state is not FULL, derived from registered state only.
REQ-023 out_valid SHALL be 1 exactly when the state is not EMPTY; outputs SHALL present the oldest entry.
REQ-024 Latency SHALL be 1 cycle: a bundle accepted at edge N is visible on the outputs after edge N.
REQ-025 State transitions SHALL be:
- push only: EMPTY->ONE, ONE->FULL.
- pop only: FULL->ONE, ONE->EMPTY.
- push and pop in ONE: stays ONE.
- push and pop in EMPTY: impossible, since out_valid=0.
REQ-026 The outputs SHALL hold stable while out_valid && !out_ready.
REQ-027 flush=1 SHALL force EMPTY at the next edge, discarding any concurrent input, with priority over push and pop.
REQ-028 Bundles accepted while flush=1 SHALL NOT be considered accepted for any purpose.
REQ-029 illegal_cnt SHALL add the number of illegal valid slots (0..ISSUE_W) on each non-flushed acceptance.
REQ-030 illegal_cnt SHALL saturate at 32'hFFFF_FFFF and SHALL NOT be cleared by flush.

Reset
REQ-031 On reset, state SHALL be EMPTY, so out_valid=0 and in_ready=1.
REQ-032 On reset, out_ctrl, out_instr, out_slot_valid, out_illegal_any and illegal_cnt SHALL be 0.
REQ-033 Reset SHALL take priority over flush, push and pop, including mid-stream with the buffer FULL.

Structure
REQ-034 Package decode_pkg SHALL hold: ctrl_t, CTRL_W, the opcode constants, and aluop encodings:
- 000 R-type.
- 001 add.
- 010 sub.
- 011 and.
- 100 or.
- 101 slt.
- 110 lui.
- 111 xor.
REQ-035 A combinational sub-module slot_decoder (opcode, slot_valid -> ctrl_t) SHALL be instantiated ISSUE_W times via generate.

Verification
REQ-036 After reset, push a bundle with slots {addi 0x20080005, lw 0x8C090000} and hold out_ready=1 -> out_ctrl slot0 = 1_010_000_00_001 with illegal=0, slot1 = 1_010_001_00_001, both one cycle after acceptance.
REQ-037 Slot opcode 111111 with valid=1, plus slot1 valid=0 -> slot0 illegal=1 with zero controls, slot1 all-zero, out_illegal_any=1, illegal_cnt=1.
REQ-038 With out_ready=0, offer three bundles A, B, C -> A and B accepted, in_ready=0 after the 2nd, C stalls; release out_ready -> order A, B, C with no loss or duplication.
REQ-039 Buffer FULL, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed bundle is never output, illegal_cnt unchanged.
REQ-040 Preload illegal_cnt to 32'hFFFF_FFFE via force, accept 2 illegal slots -> illegal_cnt = 32'hFFFF_FFFF.
REQ-041 Assert reset while FULL and out_ready=0 -> next cycle all outputs 0 and in_ready=1.
